// File: rtl/frame_buffer_pad.sv
// frame_buffer_pad: pulls PCM samples from a FIFO into a FRAME_SIZE-deep circular buffer. It streams
// each frame zero-padded to PAD_SIZE samples, one per cycle with its index, and then advances the
// frame start by MOVE_SIZE. An end-of-stream flush completes a partial frame with zeros.
//
// Handshakes:
//   FIFO side  : fifo_rd_en_o is a read request. Data for a request issued in cycle N is taken from
//                fifo_data_i in cycle N+1. A request is never issued while fifo_empty_i=1.
//   Output side: out_valid_o qualifies out_ptr_o/out_sample_o for the cycle it is high. There is no
//                ready/back-pressure, so the consumer must accept one sample per cycle for the whole
//                frame.
module frame_buffer_pad #(
  parameter int WIDTH      = 16,
  parameter int FRAME_SIZE = 400,
  parameter int MOVE_SIZE  = 160,
  parameter int PAD_SIZE   = 512,
  parameter bit AUTO_START = 1'b0,
  localparam int PTR_W     = (PAD_SIZE > 1) ? $clog2(PAD_SIZE) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             fifo_rd_en_o,
  input  logic [WIDTH-1:0] fifo_data_i,
  input  logic             fifo_empty_i,
  input  logic             start_i,
  input  logic             flush_i,
  output logic             frame_ready_o,
  output logic             out_valid_o,
  output logic [PTR_W-1:0] out_ptr_o,
  output logic [WIDTH-1:0] out_sample_o,
  output logic             frame_done_o,
  output logic             flush_done_o,
  output logic [15:0]      frame_count_o,
  output logic [1:0]       dbg_state_o
);

  localparam int IDX_W  = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam int NEED_W = $clog2(FRAME_SIZE + 1);
  localparam int SUM_W  = IDX_W + 1;
  localparam int AW     = ((SUM_W > PTR_W) ? SUM_W : PTR_W) + 1;

  localparam logic [SUM_W-1:0]  FRAME_S = SUM_W'(FRAME_SIZE);
  localparam logic [SUM_W-1:0]  MOVE_S  = SUM_W'(MOVE_SIZE);
  localparam logic [AW-1:0]     FRAME_A = AW'(FRAME_SIZE);
  localparam logic [NEED_W-1:0] MOVE_N  = NEED_W'(MOVE_SIZE);
  localparam logic [NEED_W-1:0] FRAME_N = NEED_W'(FRAME_SIZE);
  localparam logic [PTR_W-1:0]  LAST_P  = PTR_W'(PAD_SIZE - 1);

  if (!(MOVE_SIZE >= 1 && MOVE_SIZE <= FRAME_SIZE && FRAME_SIZE <= PAD_SIZE)) begin : g_param_check
    $error("frame_buffer_pad: parameters must satisfy 1 <= MOVE_SIZE <= FRAME_SIZE <= PAD_SIZE");
  end

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_READY   = 2'd1,
    ST_STREAM  = 2'd2,
    ST_ADVANCE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   head_q;         // buffer index of sample 0 of the current frame
  logic [NEED_W-1:0]  need_q;         // samples still missing before the frame is complete
  logic               rd_pend_q;      // a FIFO read was issued last cycle, data arrives now
  logic               flush_pend_q;   // end of input seen, not yet consumed
  logic               real_seen_q;    // a FIFO sample was written since the last frame
  logic               zero_fill_q;    // this frame has been completed with flush zeros
  logic               flush_abort_q;  // flush with nothing new to emit, pulse flush_done_o
  logic [PTR_W-1:0]   ptr_q;
  logic [15:0]        count_q;
  logic [WIDTH-1:0]   frame_mem [FRAME_SIZE];

  logic               flush_act;
  logic               rd_en;
  logic               wr_real;
  logic               wr_zero;
  logic               flush_abort;
  logic [SUM_W-1:0]   wr_sum;
  logic [IDX_W-1:0]   wr_idx;
  logic [AW-1:0]      rd_sum;
  logic [IDX_W-1:0]   rd_idx;
  logic               ptr_in_frame;
  logic [SUM_W-1:0]   head_sum;
  logic [IDX_W-1:0]   head_next;

  // A flush raised this cycle acts at once, so an idle flush is acknowledged on the next cycle.
  assign flush_act = flush_pend_q | flush_i;

  // Circular index arithmetic: operands are always below FRAME_SIZE, so one conditional subtract
  // is enough and FRAME_SIZE need not be a power of two.
  always_comb begin
    wr_sum    = SUM_W'(head_q) + (FRAME_S - SUM_W'(need_q));
    wr_idx    = (wr_sum >= FRAME_S) ? IDX_W'(wr_sum - FRAME_S) : IDX_W'(wr_sum);
    rd_sum    = AW'(head_q) + AW'(ptr_q);
    rd_idx    = (rd_sum >= FRAME_A) ? IDX_W'(rd_sum - FRAME_A) : IDX_W'(rd_sum);
    head_sum  = SUM_W'(head_q) + MOVE_S;
    head_next = (head_sum >= FRAME_S) ? IDX_W'(head_sum - FRAME_S) : IDX_W'(head_sum);
    ptr_in_frame = (AW'(ptr_q) < FRAME_A);
  end

  // Next-state, FIFO/buffer control and output decode.
  always_comb begin
    state_d       = state_q;
    rd_en         = 1'b0;
    wr_real       = 1'b0;
    wr_zero       = 1'b0;
    flush_abort   = 1'b0;
    frame_ready_o = 1'b0;
    out_valid_o   = 1'b0;
    out_ptr_o     = '0;
    out_sample_o  = '0;
    frame_done_o  = 1'b0;
    flush_done_o  = flush_abort_q;
    case (state_q)
      ST_FILL: begin
        wr_real = rd_pend_q;
        // An outstanding read already covers one of the missing samples.
        rd_en   = rst_n && !fifo_empty_i && (need_q > NEED_W'(rd_pend_q));
        if (!rd_pend_q && fifo_empty_i && flush_act) begin
          if (real_seen_q) begin
            wr_zero = (need_q != '0);
          end else begin
            // Nothing new since the last frame: acknowledge the flush without a frame.
            flush_abort = 1'b1;
          end
        end
        if ((wr_real || wr_zero) && need_q == NEED_W'(1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        frame_ready_o = 1'b1;
        if (start_i || AUTO_START) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        out_valid_o  = 1'b1;
        out_ptr_o    = ptr_q;
        out_sample_o = ptr_in_frame ? frame_mem[rd_idx] : '0;
        if (ptr_q == LAST_P) begin
          state_d = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        frame_done_o = 1'b1;
        flush_done_o = flush_abort_q | zero_fill_q;
        state_d      = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  assign fifo_rd_en_o  = rd_en;
  assign frame_count_o = count_q;
  assign dbg_state_o   = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame bookkeeping: fill level, head, stream pointer, flush tracking and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q        <= '0;
      need_q        <= FRAME_N;
      rd_pend_q     <= 1'b0;
      flush_pend_q  <= 1'b0;
      real_seen_q   <= 1'b0;
      zero_fill_q   <= 1'b0;
      flush_abort_q <= 1'b0;
      ptr_q         <= '0;
      count_q       <= '0;
    end else begin
      rd_pend_q     <= rd_en;
      flush_abort_q <= flush_abort;

      if (flush_abort || (state_q == ST_ADVANCE && zero_fill_q)) begin
        flush_pend_q <= 1'b0;
      end else if (flush_i) begin
        flush_pend_q <= 1'b1;
      end

      if (wr_real || wr_zero) begin
        need_q <= need_q - NEED_W'(1);
      end
      if (wr_real) begin
        real_seen_q <= 1'b1;
      end
      if (wr_zero) begin
        zero_fill_q <= 1'b1;
      end

      if (state_q == ST_READY) begin
        ptr_q <= '0;
      end else if (state_q == ST_STREAM) begin
        ptr_q <= ptr_q + PTR_W'(1);
      end

      if (state_q == ST_ADVANCE) begin
        head_q      <= head_next;
        need_q      <= MOVE_N;
        count_q     <= count_q + 16'd1;
        real_seen_q <= 1'b0;
        zero_fill_q <= 1'b0;
      end
    end
  end

  // Sample storage: FIFO data or flush zeros land at the next free slot of the frame.
  always_ff @(posedge clk) begin
    if (wr_real) begin
      frame_mem[wr_idx] <= fifo_data_i;
    end else if (wr_zero) begin
      frame_mem[wr_idx] <= '0;
    end
  end

endmodule

// File: tb/tb_frame_buffer_pad.sv
// tb_frame_buffer_pad: directed bench for frame_buffer_pad (default sizes, manual start) plus a small
// auto-start instance sharing clock and reset.
module tb_frame_buffer_pad;

  localparam int WIDTH = 16;
  localparam int FRAME = 400;
  localparam int PAD   = 512;
  localparam int PTR_W = 9;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main instance ----------------
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_data = '0;
  logic             fifo_empty = 1'b1;
  logic             start = 1'b0;
  logic             flush = 1'b0;
  logic             frame_ready, out_valid, frame_done, flush_done;
  logic [PTR_W-1:0] out_ptr;
  logic [WIDTH-1:0] out_sample;
  logic [15:0]      frame_count;
  logic [1:0]       dbg_state;

  frame_buffer_pad dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_rd_en_o(fifo_rd_en), .fifo_data_i(fifo_data), .fifo_empty_i(fifo_empty),
    .start_i(start), .flush_i(flush),
    .frame_ready_o(frame_ready), .out_valid_o(out_valid), .out_ptr_o(out_ptr),
    .out_sample_o(out_sample), .frame_done_o(frame_done), .flush_done_o(flush_done),
    .frame_count_o(frame_count), .dbg_state_o(dbg_state)
  );

  // ---------------- auto-start instance (8 / 4 / 16) ----------------
  logic             b_rd_en;
  logic [WIDTH-1:0] b_data;
  logic [WIDTH-1:0] b_cnt;
  logic             b_empty = 1'b0;
  logic             b_start = 1'b0;
  logic             b_flush = 1'b0;
  logic             b_ready, b_valid, b_done, b_fdone;
  logic [3:0]       b_ptr;
  logic [WIDTH-1:0] b_sample;
  logic [15:0]      b_count;
  logic [1:0]       b_state;

  frame_buffer_pad #(.FRAME_SIZE(8), .MOVE_SIZE(4), .PAD_SIZE(16), .AUTO_START(1'b1)) dut_auto (
    .clk(clk), .rst_n(rst_n),
    .fifo_rd_en_o(b_rd_en), .fifo_data_i(b_data), .fifo_empty_i(b_empty),
    .start_i(b_start), .flush_i(b_flush),
    .frame_ready_o(b_ready), .out_valid_o(b_valid), .out_ptr_o(b_ptr),
    .out_sample_o(b_sample), .frame_done_o(b_done), .flush_done_o(b_fdone),
    .frame_count_o(b_count), .dbg_state_o(b_state)
  );

  // Endless ramp source 1,2,3,... for the auto-start instance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_cnt  <= 16'd1;
      b_data <= '0;
    end else if (b_rd_en) begin
      b_data <= b_cnt;
      b_cnt  <= b_cnt + 16'd1;
    end
  end

  // ---------------- FIFO model for the main instance ----------------
  logic [WIDTH-1:0] fq[$];
  bit gap_en = 1'b0;
  bit gap    = 1'b0;
  int rd_cnt  = 0;
  int rd_viol = 0;

  // Pop on a read request; data shows up the following cycle.
  always @(posedge clk) begin
    if (rst_n && fifo_rd_en) begin
      if (fifo_empty) rd_viol++;
      else begin
        fifo_data <= fq.pop_front();
        rd_cnt++;
      end
    end
  end

  // Empty flag (with optional random gaps) changes only on the falling edge.
  always @(negedge clk) begin
    gap        = gap_en && ($urandom_range(0, 1) == 1);
    fifo_empty = (fq.size() == 0) || gap;
  end

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_ramp(input int last);
    fq.delete();
    for (int i = 1; i <= last; i++) fq.push_back(WIDTH'(i));
  endtask

  // Wait (bounded) for frame_ready_o, making sure nothing streams early.
  task automatic wait_ready(input string tag);
    int n = 0;
    int early = 0;
    while (frame_ready !== 1'b1 && n < 4000) begin
      if (out_valid === 1'b1) early++;
      @(negedge clk);
      n++;
    end
    chk({tag, " ready_reached"}, frame_ready, 1);
    chk({tag, " no_early_stream"}, early, 0);
  endtask

  // Called at a negedge with frame_ready_o=1. Checks one padded frame and the ADVANCE cycle.
  task automatic run_frame(input string tag, input int first, input int last_real, input bit exp_fd,
                           input int exp_cnt, input bit drive_start, input int spot_idx,
                           input int spot_val);
    int bad = 0;
    logic [WIDTH-1:0] e;
    if (drive_start) start = 1'b1;
    @(negedge clk);
    if (drive_start) start = 1'b0;
    chk({tag, " valid_rise"}, out_valid, 1);
    chk({tag, " ready_drop"}, frame_ready, 0);
    for (int p = 0; p < PAD; p++) begin
      if (p < FRAME && first + p <= last_real) exp_q.push_back(WIDTH'(first + p));
      else exp_q.push_back('0);
    end
    for (int p = 0; p < PAD; p++) begin
      e = exp_q.pop_front();
      if (!(out_valid === 1'b1 && out_ptr === PTR_W'(p) && out_sample === e)) bad++;
      if (p == 0)        chk({tag, " ptr0_sample"}, out_sample, first);
      if (p == spot_idx) chk({tag, " spot_sample"}, out_sample, spot_val);
      if (p == FRAME)    chk({tag, " first_pad_zero"}, out_sample, 0);
      @(negedge clk);
    end
    chk({tag, " frame_samples_bad"}, bad, 0);
    chk({tag, " frame_done"}, frame_done, 1);
    chk({tag, " valid_fall"}, out_valid, 0);
    chk({tag, " flush_done"}, flush_done, exp_fd);
    @(negedge clk);
    chk({tag, " frame_count"}, frame_count, exp_cnt);
    chk({tag, " done_one_cycle"}, frame_done, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rd_base;
    int n;
    int bad;

    // Scenario 1: reset values, then first frame from ramp 1..1000, manual start.
    load_ramp(1000);
    repeat (3) @(negedge clk);
    chk("rst rd_en", fifo_rd_en, 0);
    chk("rst ready", frame_ready, 0);
    chk("rst valid", out_valid, 0);
    chk("rst ptr", out_ptr, 0);
    chk("rst sample", out_sample, 0);
    chk("rst done", frame_done, 0);
    chk("rst flush_done", flush_done, 0);
    chk("rst count", frame_count, 0);
    rst_n = 1'b1;
    wait_ready("s1");
    chk("s1 reads_for_frame", rd_cnt, 400);
    repeat (5) @(negedge clk);
    chk("s1 ready_held", frame_ready, 1);
    chk("s1 no_auto_start", out_valid, 0);
    run_frame("s1", 1, 1000, 1'b0, 1, 1'b1, 399, 400);

    // Scenario 2: hop of 160, head wraps past 400.
    rd_base = rd_cnt;
    wait_ready("s2a");
    chk("s2a reads_for_hop", rd_cnt - rd_base, 160);
    run_frame("s2a", 161, 1000, 1'b0, 2, 1'b1, 399, 560);
    rd_base = rd_cnt;
    wait_ready("s2b");
    chk("s2b reads_for_hop", rd_cnt - rd_base, 160);
    run_frame("s2b", 321, 1000, 1'b0, 3, 1'b1, 399, 720);

    // Scenario 3 (+5a): random empty gaps, start_i held from reset through FILL.
    rst_n = 1'b0;
    load_ramp(1000);
    gap_en  = 1'b1;
    rd_viol = 0;
    start   = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ready("s3a");
    run_frame("s3a", 1, 1000, 1'b0, 1, 1'b0, 399, 400);
    wait_ready("s3b");
    run_frame("s3b", 161, 1000, 1'b0, 2, 1'b0, 399, 560);
    wait_ready("s3c");
    run_frame("s3c", 321, 1000, 1'b0, 3, 1'b0, 399, 720);
    start  = 1'b0;
    gap_en = 1'b0;
    chk("s3 read_while_empty", rd_viol, 0);

    // Scenario 4: 450 samples then flush; second flush with nothing pending.
    rst_n = 1'b0;
    load_ramp(450);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_ready("s4a");
    run_frame("s4a", 1, 450, 1'b0, 1, 1'b1, 399, 400);
    wait_ready("s4b");
    run_frame("s4b", 161, 450, 1'b1, 2, 1'b1, 289, 450);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("s4 idle_flush_done", flush_done, 1);
    @(negedge clk);
    chk("s4 idle_flush_done_one_cycle", flush_done, 0);
    bad = 0;
    repeat (30) begin
      if (frame_ready !== 1'b0 || out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("s4 idle_flush_no_frame", bad, 0);
    chk("s4 idle_flush_count", frame_count, 2);

    // Scenario 6: reset at ptr=200 of the second frame, then a fresh ramp.
    rst_n = 1'b0;
    load_ramp(1000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ready("s6a");
    run_frame("s6a", 1, 1000, 1'b0, 1, 1'b1, 399, 400);
    wait_ready("s6b");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    chk("s6 at_ptr200", out_ptr, 200);
    chk("s6 sample_ptr200", out_sample, 361);
    rst_n = 1'b0;
    #1;
    chk("s6 async valid", out_valid, 0);
    chk("s6 async ptr", out_ptr, 0);
    chk("s6 async sample", out_sample, 0);
    chk("s6 async ready", frame_ready, 0);
    chk("s6 async count", frame_count, 0);
    chk("s6 async rd_en", fifo_rd_en, 0);
    load_ramp(400);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ready("s6c");
    run_frame("s6c", 1, 400, 1'b0, 1, 1'b1, 399, 400);

    // Scenario 5b: auto-start instance (frame 8, hop 4, pad 16) needs no start_i.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (b_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("s5 auto ready_reached", b_ready, 1);
    @(negedge clk);
    chk("s5 auto valid_next_cycle", b_valid, 1);
    chk("s5 auto ready_drop", b_ready, 0);
    chk("s5 auto ptr0", b_ptr, 0);
    chk("s5 auto ptr0_sample", b_sample, 1);
    repeat (7) @(negedge clk);
    chk("s5 auto ptr7", b_ptr, 7);
    chk("s5 auto ptr7_sample", b_sample, 8);
    @(negedge clk);
    chk("s5 auto ptr8_pad", b_sample, 0);
    repeat (7) @(negedge clk);
    chk("s5 auto ptr15", b_ptr, 15);
    @(negedge clk);
    chk("s5 auto frame_done", b_done, 1);
    chk("s5 auto valid_fall", b_valid, 0);
    n = 0;
    while (b_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("s5 auto ready2", b_ready, 1);
    @(negedge clk);
    chk("s5 auto frame2_ptr0", b_sample, 5);
    chk("s5 auto count", b_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case a wait escapes its bound.
  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected sequence end");
    $fatal(1, "watchdog expired");
  end

endmodule
